// File: rtl/draw_scan_if.sv
// Bus between draw_scan and its neighbours: the blit rectangle from the address stage, the VRAM command port and the status outputs.
// The master modport is the scan block's view, and the slave modport is the environment's view.
interface draw_scan_if;
    logic        STARTBLT;
    logic [1:0]  VALID;
    logic [8:0]  OVA_SPOSX;
    logic [13:0] OVA_SPOSY;
    logic [8:0]  OVA_DPOSX;
    logic [13:0] OVA_DPOSY;
    logic [8:0]  OVA_WIDTH;
    logic [9:0]  OVA_HEIGHT;
    logic        CMD_ACK;
    logic        CMD_REQ;
    logic        CMD_WRITE;
    logic [22:0] CMD_ADR;
    logic [8:0]  CMD_LEN;
    logic        BUSY_SCAN;
    logic        DONE_SCAN;
    logic [1:0]  ERROR_SCAN;

    modport master (
        input  STARTBLT, VALID, OVA_SPOSX, OVA_SPOSY, OVA_DPOSX, OVA_DPOSY,
               OVA_WIDTH, OVA_HEIGHT, CMD_ACK,
        output CMD_REQ, CMD_WRITE, CMD_ADR, CMD_LEN, BUSY_SCAN, DONE_SCAN, ERROR_SCAN
    );

    modport slave (
        output STARTBLT, VALID, OVA_SPOSX, OVA_SPOSY, OVA_DPOSX, OVA_DPOSY,
               OVA_WIDTH, OVA_HEIGHT, CMD_ACK,
        input  CMD_REQ, CMD_WRITE, CMD_ADR, CMD_LEN, BUSY_SCAN, DONE_SCAN, ERROR_SCAN
    );
endinterface

// File: rtl/draw_scan.sv
// Walks a blit rectangle row by row and issues VRAM burst commands (<= MAXBURST words) over REQ/ACK; first REQ 1 cycle after STARTBLT.
// Commands hold stable until ACK. Optional DRAW_SCAN_BOUNDCHK_EN rejects rectangles that overrun the address fields.
module draw_scan #(
    parameter int unsigned MAXBURST = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INIT,
    draw_scan_if.master bus
);

    typedef enum logic [2:0] {IDLE, RD, WR, NEXT, FIN} state_t;

    localparam logic [9:0] MAXB = 10'(MAXBURST);

    state_t      state_q, state_d;
    logic        bitblt_q, bitblt_d;
    logic [8:0]  sposx_q, sposx_d, dposx_q, dposx_d, width_q, width_d;
    logic [13:0] sposy_q, sposy_d, dposy_q, dposy_d;
    logic [9:0]  height_q, height_d;
    logic [9:0]  xoff_q, xoff_d, row_q, row_d;
    logic [1:0]  err_q, err_d;

    logic [9:0]  rem, xnext, row_inc;
    logic [8:0]  len, posx, adr_x;
    logic [13:0] posy, adr_y;
    logic        start_ok, oob;

    // Burst geometry is derived from the registered counters only
    always_comb begin
        rem     = {1'b0, width_q} - xoff_q;
        len     = (rem > MAXB) ? MAXB[8:0] : rem[8:0];
        xnext   = xoff_q + {1'b0, len};
        row_inc = row_q + 10'd1;
        posx    = (state_q == RD) ? sposx_q : dposx_q;
        posy    = (state_q == RD) ? sposy_q : dposy_q;
        adr_x   = posx + xoff_q[8:0];
        adr_y   = posy + {4'b0, row_q};
    end

    assign start_ok = bus.STARTBLT && (bus.VALID == 2'b01 || bus.VALID == 2'b10);

`ifdef DRAW_SCAN_BOUNDCHK_EN
    always_comb begin
        oob = (({1'b0, bus.OVA_DPOSY} + {5'b0, bus.OVA_HEIGHT}) > 15'd16384) ||
              (({1'b0, bus.OVA_DPOSX} + {1'b0, bus.OVA_WIDTH}) > 10'd512);
        if (bus.VALID[1])
            oob = oob ||
                  (({1'b0, bus.OVA_SPOSY} + {5'b0, bus.OVA_HEIGHT}) > 15'd16384) ||
                  (({1'b0, bus.OVA_SPOSX} + {1'b0, bus.OVA_WIDTH}) > 10'd512);
    end
`else
    assign oob = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else if (INIT) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bitblt_q <= 1'b0; sposx_q <= '0; sposy_q <= '0; dposx_q <= '0; dposy_q <= '0;
            width_q  <= '0;   height_q <= '0; xoff_q <= '0; row_q <= '0; err_q <= '0;
        end else if (INIT) begin
            bitblt_q <= 1'b0; sposx_q <= '0; sposy_q <= '0; dposx_q <= '0; dposy_q <= '0;
            width_q  <= '0;   height_q <= '0; xoff_q <= '0; row_q <= '0; err_q <= '0;
        end else begin
            bitblt_q <= bitblt_d; sposx_q <= sposx_d; sposy_q <= sposy_d;
            dposx_q  <= dposx_d;  dposy_q <= dposy_d; width_q <= width_d;
            height_q <= height_d; xoff_q  <= xoff_d;  row_q   <= row_d; err_q <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitblt_d = bitblt_q;
        sposx_d  = sposx_q;
        sposy_d  = sposy_q;
        dposx_d  = dposx_q;
        dposy_d  = dposy_q;
        width_d  = width_q;
        height_d = height_q;
        xoff_d   = xoff_q;
        row_d    = row_q;
        err_d    = err_q;

        if (bus.STARTBLT && state_q != IDLE)
            err_d[0] = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    bitblt_d = bus.VALID[1];
                    sposx_d  = bus.OVA_SPOSX;
                    sposy_d  = bus.OVA_SPOSY;
                    dposx_d  = bus.OVA_DPOSX;
                    dposy_d  = bus.OVA_DPOSY;
                    width_d  = bus.OVA_WIDTH;
                    height_d = bus.OVA_HEIGHT;
                    xoff_d   = '0;
                    row_d    = '0;
                    if (oob) begin
                        err_d[1] = 1'b1;
                        state_d  = FIN;
                    end else if (bus.OVA_WIDTH == '0 || bus.OVA_HEIGHT == '0) begin
                        state_d  = FIN;
                    end else begin
                        state_d  = bus.VALID[1] ? RD : WR;
                    end
                end
            end
            RD: begin
                if (bus.CMD_ACK)
                    state_d = WR;
            end
            WR: begin
                if (bus.CMD_ACK) begin
                    xoff_d  = xnext;
                    state_d = (xnext < {1'b0, width_q}) ? (bitblt_q ? RD : WR) : NEXT;
                end
            end
            NEXT: begin
                xoff_d  = '0;
                row_d   = row_inc;
                state_d = (row_inc == height_q) ? FIN : (bitblt_q ? RD : WR);
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.CMD_REQ    = (state_q == RD) || (state_q == WR);
        bus.CMD_WRITE  = (state_q == WR);
        bus.CMD_ADR    = bus.CMD_REQ ? {adr_y, adr_x} : '0;
        bus.CMD_LEN    = bus.CMD_REQ ? len : '0;
        bus.BUSY_SCAN  = (state_q != IDLE);
        bus.DONE_SCAN  = (state_q == FIN);
        bus.ERROR_SCAN = err_q;
    end

endmodule

// File: tb/tb_draw_scan.sv
// Directed bench for draw_scan: command sequence, handshake timing, stalls, errors, INIT abort and address wrap.
module tb_draw_scan;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic INIT = 1'b0;
    always #5 CLK = ~CLK;

    draw_scan_if bus();

    draw_scan #(.MAXBURST(64)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .INIT (INIT),
        .bus  (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int start_cyc = 0;
    int done_cnt  = 0;
    int done_base = 0;
    int done_cyc  = 0;
    logic req_seen = 1'b0;
    logic [63:0] acc_q[$];
    int          acc_cyc[$];
    logic [63:0] exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.CMD_REQ) req_seen = 1'b1;
        if (bus.CMD_REQ && bus.CMD_ACK) begin
            acc_q.push_back({31'b0, bus.CMD_WRITE, bus.CMD_ADR, bus.CMD_LEN});
            acc_cyc.push_back(cyc);
        end
        if (bus.DONE_SCAN) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cmd(input logic w, input int y, input int x, input int l);
        logic [13:0] yy = 14'(y);
        logic [8:0]  xx = 9'(x);
        logic [8:0]  ll = 9'(l);
        return {31'b0, w, yy, xx, ll};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [1:0] v, input int sx, input int sy, input int dx,
                         input int dy, input int w, input int h);
        acc_q.delete();
        acc_cyc.delete();
        exp_q.delete();
        req_seen  = 1'b0;
        done_base = done_cnt;
        bus.STARTBLT   = 1'b1;
        bus.VALID      = v;
        bus.OVA_SPOSX  = 9'(sx);
        bus.OVA_SPOSY  = 14'(sy);
        bus.OVA_DPOSX  = 9'(dx);
        bus.OVA_DPOSY  = 14'(dy);
        bus.OVA_WIDTH  = 9'(w);
        bus.OVA_HEIGHT = 10'(h);
        step();
        bus.STARTBLT = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 1000; i++) begin
            if (done_cnt != done_base) break;
            step();
        end
        step();
        check("done_count", 64'(done_cnt - done_base), 64'd1);
    endtask

    task automatic compare_cmds(input string tag);
        check({tag, "_ncmd"}, 64'(acc_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_cmd%0d", tag, i), acc_q[i], exp_q[i]);
    endtask

    initial begin
        bus.STARTBLT = 1'b0; bus.VALID = 2'b00; bus.CMD_ACK = 1'b0;
        bus.OVA_SPOSX = '0; bus.OVA_SPOSY = '0; bus.OVA_DPOSX = '0; bus.OVA_DPOSY = '0;
        bus.OVA_WIDTH = '0; bus.OVA_HEIGHT = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        step();

        check("rst_req",  64'(bus.CMD_REQ), 64'd0);
        check("rst_wr",   64'(bus.CMD_WRITE), 64'd0);
        check("rst_adr",  64'(bus.CMD_ADR), 64'd0);
        check("rst_len",  64'(bus.CMD_LEN), 64'd0);
        check("rst_busy", 64'(bus.BUSY_SCAN), 64'd0);
        check("rst_done", 64'(bus.DONE_SCAN), 64'd0);
        check("rst_err",  64'(bus.ERROR_SCAN), 64'd0);

        // PATBLT 4x2: one idle cycle between rows, DONE two cycles after last accept
        bus.CMD_ACK = 1'b1;
        start(2'b01, 0, 0, 10, 100, 4, 2);
        check("pat_busy", 64'(bus.BUSY_SCAN), 64'd1);
        wait_done();
        exp_q.push_back(cmd(1, 100, 10, 4));
        exp_q.push_back(cmd(1, 101, 10, 4));
        compare_cmds("pat");
        if (acc_cyc.size() == 2) begin
            check("pat_first_lat", 64'(acc_cyc[0] - start_cyc), 64'd0);
            check("pat_row_gap",   64'(acc_cyc[1] - acc_cyc[0]), 64'd2);
            check("pat_done_lat",  64'(done_cyc - acc_cyc[1]), 64'd2);
        end

        // BITBLT 3x1: read then write at the same offset
        start(2'b10, 0, 5, 20, 7, 3, 1);
        wait_done();
        exp_q.push_back(cmd(0, 5, 0, 3));
        exp_q.push_back(cmd(1, 7, 20, 3));
        compare_cmds("bit");
        if (acc_cyc.size() == 2)
            check("bit_rd_wr_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
        check("bit_busy_after", 64'(bus.BUSY_SCAN), 64'd0);

        // Wide row split into 64/64/22, back to back
        start(2'b01, 0, 0, 0, 3, 150, 1);
        wait_done();
        exp_q.push_back(cmd(1, 3, 0, 64));
        exp_q.push_back(cmd(1, 3, 64, 64));
        exp_q.push_back(cmd(1, 3, 128, 22));
        compare_cmds("split");
        if (acc_cyc.size() == 3)
            check("split_b2b", 64'(acc_cyc[2] - acc_cyc[0]), 64'd2);

        // ACK withheld for 5 cycles on the first burst
        bus.CMD_ACK = 1'b0;
        start(2'b01, 0, 0, 10, 100, 4, 2);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_req%0d", i), 64'(bus.CMD_REQ), 64'd1);
            check($sformatf("stall_adr%0d", i), 64'(bus.CMD_ADR), 64'({14'd100, 9'd10}));
            check($sformatf("stall_len%0d", i), 64'(bus.CMD_LEN), 64'd4);
            step();
        end
        bus.CMD_ACK = 1'b1;
        wait_done();
        exp_q.push_back(cmd(1, 100, 10, 4));
        exp_q.push_back(cmd(1, 101, 10, 4));
        compare_cmds("stall");
        if (acc_cyc.size() == 2)
            check("stall_accept_cyc", 64'(acc_cyc[0] - start_cyc), 64'd5);

        // Empty rectangles: no command, prompt DONE
        start(2'b01, 0, 0, 10, 10, 0, 3);
        wait_done();
        check("w0_nreq", 64'(req_seen), 64'd0);
        check("w0_lat",  64'((done_cyc - start_cyc) <= 1), 64'd1);
        start(2'b10, 0, 0, 10, 10, 5, 0);
        wait_done();
        check("h0_nreq", 64'(req_seen), 64'd0);

        // STARTBLT while busy flags an error and is otherwise ignored
        start(2'b01, 0, 0, 10, 100, 4, 2);
        bus.STARTBLT = 1'b1; bus.VALID = 2'b01; bus.OVA_DPOSX = 9'd0; bus.OVA_DPOSY = 14'd0;
        step();
        bus.STARTBLT = 1'b0;
        wait_done();
        exp_q.push_back(cmd(1, 100, 10, 4));
        exp_q.push_back(cmd(1, 101, 10, 4));
        compare_cmds("busy");
        check("busy_err", 64'(bus.ERROR_SCAN), 64'd1);
        INIT = 1'b1;
        step();
        INIT = 1'b0;
        check("init_clr_err", 64'(bus.ERROR_SCAN), 64'd0);

        // INIT in mid-row aborts with no DONE
        bus.CMD_ACK = 1'b0;
        start(2'b01, 0, 0, 0, 0, 150, 2);
        step();
        check("abort_req_before", 64'(bus.CMD_REQ), 64'd1);
        INIT = 1'b1;
        step();
        INIT = 1'b0;
        check("abort_req", 64'(bus.CMD_REQ), 64'd0);
        check("abort_busy", 64'(bus.BUSY_SCAN), 64'd0);
        repeat (5) step();
        check("abort_nodone", 64'(done_cnt - done_base), 64'd0);
        bus.CMD_ACK = 1'b1;

        // Illegal kinds are ignored
        start(2'b11, 0, 0, 0, 0, 4, 1);
        check("v11_busy", 64'(bus.BUSY_SCAN), 64'd0);
        start(2'b00, 0, 0, 0, 0, 4, 1);
        check("v00_busy", 64'(bus.BUSY_SCAN), 64'd0);
        repeat (3) step();
        check("vbad_nreq", 64'(req_seen), 64'd0);

`ifdef DRAW_SCAN_BOUNDCHK_EN
        start(2'b01, 0, 0, 500, 0, 20, 1);
        wait_done();
        check("bound_nreq", 64'(req_seen), 64'd0);
        check("bound_err",  64'(bus.ERROR_SCAN), 64'd2);
`else
        // Row field wraps with no carry from x
        start(2'b01, 0, 0, 505, 16383, 10, 2);
        wait_done();
        exp_q.push_back(cmd(1, 16383, 505, 10));
        exp_q.push_back(cmd(1, 0, 505, 10));
        compare_cmds("wrap");
        check("wrap_err", 64'(bus.ERROR_SCAN), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
